mmio_uart_tx: RTL

Memory-mapped console transmitter on the CPU's data-memory side, downstream of the MEM stage. It decodes store/load strobes from the core, buffers stored bytes in a small FIFO, and serialises them as 8N1 UART frames on a single output pin. It gives multicycle-core programs a console path, so benches stop reading register state through hierarchical peeks.

---
 rtl/brisc_mmio_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/mmio_uart_tx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/brisc_mmio_pkg.sv
// Shared definitions for the memory-mapped console transmitter: register
// offsets, STATUS bit positions, transmitter states and the default base address.
package brisc_mmio_pkg;

  localparam logic [31:0] UART_BASE_DEFAULT = 32'h1000_0000;

  localparam logic [2:0] TXDATA_OFF = 3'd0;
  localparam logic [2:0] STATUS_OFF = 3'd4;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_ACTIVE    = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_PARITY    = 4;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output; pushes when full and
// pops when empty are ignored, and the pointers wrap modulo DEPTH.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Acceptance is judged on the pre-edge count, so a push into a non-full
  // FIFO always lands even if a pop happens on the same edge.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART console transmitter: TXDATA/STATUS register window,
// byte FIFO and 8N1 serialiser. Define UART_TX_PARITY_EN for an even-parity bit.
module mmio_uart_tx
  import brisc_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = UART_BASE_DEFAULT,
  parameter int          DEPTH        = 4,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w_en,
  input  logic        mem_r_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif

  logic [31:0]   offset;
  logic          txdata_sel;
  logic          status_sel;
  logic          push;
  logic          status_wr;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [31:0]   status;
  logic          unused_wdata;

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] bit_cnt, cnt_n;
  logic [2:0]       bit_idx, idx_n;
  logic [7:0]       shreg, sh_n;
  logic             tx_n;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit, par_n;
`endif

  // Unsigned offset keeps the window check a single compare and makes
  // addresses below BASE_ADDR wrap to large values, i.e. misses.
  assign offset       = addr - BASE_ADDR;
  assign hit          = (offset < 32'd8);
  assign txdata_sel   = (offset == 32'(TXDATA_OFF));
  assign status_sel   = (offset == 32'(STATUS_OFF));
  assign push         = mem_w_en && txdata_sel;
  assign status_wr    = mem_w_en && status_sel;
  assign unused_wdata = ^wdata[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (status_wr) begin
      overflow <= 1'b0;
    end else if (push && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  always_comb begin
    status                            = '0;
    status[STAT_FULL]                 = fifo_full;
    status[STAT_EMPTY]                = fifo_empty;
    status[STAT_ACTIVE]               = (state != IDLE);
    status[STAT_OVERFLOW]             = overflow;
    status[STAT_PARITY]               = PARITY_FLAG;
    status[STAT_COUNT_LSB +: CW]      = fifo_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (mem_r_en && hit) begin
      rdata <= status_sel ? status : 32'h0;
    end
  end

  assign busy = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      bit_idx <= idx_n;
      shreg   <= sh_n;
      tx      <= tx_n;
`ifdef UART_TX_PARITY_EN
      parity_bit <= par_n;
`endif
    end
  end

  // tx_n is the line level for the state being entered, so the registered
  // tx changes on the same edge as the state and never glitches.
  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    idx_n   = bit_idx;
    sh_n    = shreg;
    tx_n    = tx;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = parity_bit;
`endif
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_n    = fifo_dout;
          state_n = START;
          cnt_n   = '0;
          tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_n   = ^fifo_dout;
`endif
        end
      end
      START: begin
        if (bit_cnt == CNT_MAX) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
          tx_n    = shreg[0];
        end else begin
          cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_cnt == CNT_MAX) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = parity_bit;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n = bit_idx + 3'd1;
            sh_n  = {1'b0, shreg[7:1]};
            tx_n  = shreg[1];
          end
        end else begin
          cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (bit_cnt == CNT_MAX) begin
          cnt_n   = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          cnt_n = bit_cnt + CNT_W'(1);
        end
`else
        state_n = IDLE;
        tx_n    = 1'b1;
`endif
      end
      STOP: begin
        if (bit_cnt == CNT_MAX) begin
          cnt_n   = '0;
          state_n = IDLE;
          tx_n    = 1'b1;
        end else begin
          cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule
